regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Write-side companion of the 32x32 general-register file.
- Merges results from two producers into the single register-file write port: the ALU (port 0, priority) and the load/store unit (port 1, buffered).
- Enforces write-after-write ordering per destination register, bounds LSU starvation, and drops writes to x0.
- Publishes a pending-register mask so decode can stall on in-flight destinations.

Parameters:
- DEPTH, 4, port-1 FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive port-0 write cycles with a non-empty FIFO before a forced drain.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_p0_valid  in  1  ALU result valid
- o_p0_ready  out  1  ALU result accepted when valid&ready
- i_p0_rd  in  5  ALU destination register
- i_p0_data  in  32  ALU result
- i_p1_valid  in  1  LSU result valid
- o_p1_ready  out  1  LSU result accepted when valid&ready
- i_p1_rd  in  5  LSU destination register
- i_p1_data  in  32  LSU result
- o_we  out  1  register-file write enable (registered)
- o_waddr  out  5  register-file write address (registered)
- o_wdata  out  32  register-file write data (registered)
- o_pending  out  32  bit r set when rd=r is in the FIFO or in the output register; bit 0 is always 0
- o_draining  out  1  high while in the DRAIN state

Behaviour:
Reset:
- Synchronous, active-high, takes priority over all other activity; applies mid-operation.
- Clears the FIFO, state (NORMAL), starve counter, o_we, o_waddr and o_wdata.
- After reset, o_pending = 0, o_draining = 0, o_p1_ready = 1.

Port 1 (LSU):
- o_p1_ready = FIFO not full, computed from registered occupancy.
- No push when full, even if a pop occurs in the same cycle.
- An accepted entry with rd = 0 is discarded, not pushed.

Port 0 (ALU):
- o_p0_ready = (state == NORMAL) and no valid FIFO entry has rd == i_p0_rd.
- rd = 0 is exempt from the conflict check.
- An accepted entry with rd = 0 is consumed with no write.

Write selection, evaluated per cycle; the result is registered to o_we/o_waddr/o_wdata on the next edge (latency 1):
- NORMAL, p0 accepted with rd != 0: write the p0 entry; the FIFO holds.
- NORMAL, no p0 write, FIFO non-empty: pop the head and write it.
- DRAIN: pop the head each cycle.
- Otherwise o_we = 0; o_waddr and o_wdata hold their previous values.

Timing and ordering:
- A p1 push at cycle t is popped at the earliest in t+1 and appears on o_we in t+2.
- When p0 and p1 are accepted in the same cycle, p1 is the older result. Since the p1 entry has only just been pushed, it cannot block p0 that cycle; the conflict check uses FIFO contents before the push. Therefore a p1 and a p0 result with the same rd must not be presented in the same cycle; this is an upstream responsibility, and the assertion is bench-only.

State machine:
- NORMAL -> DRAIN when (i_p0_valid and conflict) or (starve counter == STARVE_LIMIT).
- DRAIN -> NORMAL in the cycle after the FIFO becomes empty.
- During DRAIN, port-1 pushes continue and extend the drain.

Starve counter (width clog2(STARVE_LIMIT+1)):
- Increments in any NORMAL cycle where the FIFO is non-empty and p0 writes.
- Clears on any pop, on an empty FIFO, and on entering DRAIN.
- Saturates at STARVE_LIMIT.

FIFO implementation:
- Circular buffer with read/write pointers of width log2(DEPTH) that wrap modulo DEPTH.
- Occupancy is a separate count 0..DEPTH.
- Full = (count == DEPTH); empty = (count == 0).

o_pending:
- Combinational OR of the rd one-hots of all valid FIFO entries and of o_waddr when o_we = 1.
- Bit 0 is forced to 0.

Test Plan:
- Reset: assert rst with the FIFO holding 2 entries -> next cycle o_we = 0, o_pending = 0, o_p1_ready = 1, o_draining = 0, and no stale write afterwards.
- Priority and latency: p0 (rd=5, 0xAAAA0001) and p1 (rd=6, 0xBBBB0002) valid at cycle 0 -> cycle 1: we, waddr 5; cycle 2: we, waddr 6, wdata 0xBBBB0002; o_pending[6] = 1 during cycles 1-2.
- WAW conflict: FIFO holds rd=7; p0 presents rd=7 -> o_p0_ready = 0 and o_draining = 1 until rd=7 is written; the p0 write to 7 lands strictly after it.
- Full FIFO: p0 valid every cycle, push 4 p1 entries -> o_p1_ready = 0 at count 4; a 5th p1 valid is held, not lost; pointers wrap correctly after the drain.
- Starvation: continuous p0 traffic with 1 FIFO entry -> after 8 p0 writes, DRAIN is entered, o_p0_ready = 0 for one cycle, the FIFO entry is written, then NORMAL resumes.
- x0 handling: p0 rd=0 and p1 rd=0 accepted -> o_we never asserts, o_pending stays 0, FIFO count unchanged.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-side arbiter for the 32x32 general-register file.
// Merges two producers into the single register-file write port:
//   port 0 (ALU)  : priority, never buffered; stalls on WAW hazard with FIFO
//   port 1 (LSU)  : buffered in a DEPTH-entry FIFO, drained when p0 idles,
//                   on a WAW hazard, or after STARVE_LIMIT starved cycles
// Writes to x0 are dropped. o_pending lists destinations still in flight.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_p0_valid/o_p0_ready/i_p0_rd/i_p0_data   ALU result handshake
//   i_p1_valid/o_p1_ready/i_p1_rd/i_p1_data   LSU result handshake
//   o_we/o_waddr/o_wdata          registered register-file write port
//   o_pending                     in-flight destination mask (bit 0 = 0)
//   o_draining                    high while the FIFO is being force-drained
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_p0_valid,
  output logic        o_p0_ready,
  input  logic [4:0]  i_p0_rd,
  input  logic [31:0] i_p0_data,
  input  logic        i_p1_valid,
  output logic        o_p1_ready,
  input  logic [4:0]  i_p1_rd,
  input  logic [31:0] i_p1_data,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata,
  output logic [31:0] o_pending,
  output logic        o_draining
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {NORMAL = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state;
  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count, count_nxt;
  logic [SW-1:0] starve;

  logic [DEPTH-1:0] slot_vld;
  logic full, empty, conflict;
  logic p0_wr, push, pop, enter_drain;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A slot holds a live entry when its distance from the head is below the
  // occupancy; this works for any pointer wrap position.
  always_comb begin
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++)
      slot_vld[i] = (CW'(PW'(PW'(i) - rptr)) < count);
  end

  // WAW check against FIFO contents as they stand before this cycle's push.
  always_comb begin
    conflict = 1'b0;
    if (i_p0_rd != 5'd0)
      for (int i = 0; i < DEPTH; i++)
        if (slot_vld[i] && (mem_rd[i] == i_p0_rd)) conflict = 1'b1;
  end

  always_comb begin
    o_pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_vld[i]) o_pending[mem_rd[i]] = 1'b1;
    if (o_we) o_pending[o_waddr] = 1'b1;
    o_pending[0] = 1'b0;
  end

  assign o_p1_ready = !full;
  assign o_p0_ready = (state == NORMAL) && !conflict;
  assign o_draining = (state == DRAIN);

  assign p0_wr = i_p0_valid && o_p0_ready && (i_p0_rd != 5'd0);
  // p0_wr already implies NORMAL, so in NORMAL the FIFO pops only when p0 idles.
  assign pop   = !empty && ((state == DRAIN) || !p0_wr);
  // Full blocks the push even if a pop frees a slot this cycle.
  assign push  = i_p1_valid && !full && (i_p1_rd != 5'd0);

  assign count_nxt = count + CW'(push) - CW'(pop);

  assign enter_drain = (state == NORMAL) &&
                       ((i_p0_valid && conflict) || (starve == SW'(STARVE_LIMIT)));

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr]   <= i_p1_rd;
      mem_data[wptr] <= i_p1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= NORMAL;
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      starve  <= '0;
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;

      o_we <= p0_wr || pop;
      if (p0_wr) begin
        o_waddr <= i_p0_rd;
        o_wdata <= i_p0_data;
      end else if (pop) begin
        o_waddr <= mem_rd[rptr];
        o_wdata <= mem_data[rptr];
      end

      case (state)
        NORMAL: if (enter_drain) state <= DRAIN;
        // Leave as soon as the FIFO will be empty, so pushes arriving while
        // draining keep the drain going.
        DRAIN:  if (count_nxt == '0) state <= NORMAL;
        default: state <= NORMAL;
      endcase

      if (enter_drain || pop || empty)
        starve <= '0;
      else if ((state == NORMAL) && p0_wr && (starve != SW'(STARVE_LIMIT)))
        starve <= starve + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_ready, p1_valid, p1_ready;
  logic [4:0]  p0_rd, p1_rd;
  logic [31:0] p0_data, p1_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pending;
  logic        draining;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [4:0] rd; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .i_p0_valid(p0_valid), .o_p0_ready(p0_ready), .i_p0_rd(p0_rd), .i_p0_data(p0_data),
    .i_p1_valid(p1_valid), .o_p1_ready(p1_ready), .i_p1_rd(p1_rd), .i_p1_data(p1_data),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata), .o_pending(pending), .o_draining(draining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    wr_t w;
    w.rd = rd;
    w.d  = d;
    exp_q.push_back(w);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
    p0_valid = v0; p0_rd = rd0; p0_data = d0;
    p1_valid = v1; p1_rd = rd1; p1_data = d1;
    #1;
  endtask

  // Scoreboard: every register-file write must match the next expected one.
  always @(negedge clk) begin
    if (we) begin
      wr_t w;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed waddr %0h wdata %0h expected no write", waddr, wdata);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("wb_addr", {27'd0, waddr}, {27'd0, w.rd});
        chk("wb_data", wdata, w.d);
      end
    end
  end

  // Upstream must never present the same non-zero rd on both ports at once.
  always @(negedge clk) begin
    if (!rst && p0_valid && p1_valid && (p0_rd == p1_rd) && (p0_rd != 5'd0)) begin
      n_err++;
      $error("FAIL same_rd_both_ports: observed rd %0h on both expected distinct", p0_rd);
    end
  end

  initial begin
    int j;
    int k;
    logic er;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_pending", pending, 0);
    chk("rst_p1_ready", {31'd0, p1_ready}, 1);
    chk("rst_draining", {31'd0, draining}, 0);
    rst = 1'b0;
    tick();

    // Priority and latency: p0 goes first, p1 follows one cycle later.
    drive(1, 5'd5, 32'hAAAA0001, 1, 5'd6, 32'hBBBB0002);
    chk("prio_p0_ready", {31'd0, p0_ready}, 1);
    chk("prio_p1_ready", {31'd0, p1_ready}, 1);
    expect_wr(5'd5, 32'hAAAA0001);
    expect_wr(5'd6, 32'hBBBB0002);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("prio_pend_c1", pending, 32'h0000_0060);
    tick();
    chk("prio_pend_c2", pending, 32'h0000_0040);
    tick();
    chk("prio_pend_idle", pending, 0);

    // WAW: p0 to r7 must wait until the buffered r7 has been written.
    drive(1, 5'd3, 32'h3333_0003, 1, 5'd7, 32'h7777_0001);
    expect_wr(5'd3, 32'h3333_0003);
    expect_wr(5'd7, 32'h7777_0001);
    tick();
    drive(1, 5'd7, 32'h7777_0002, 0, 0, 0);
    chk("waw_p0_blocked", {31'd0, p0_ready}, 0);
    chk("waw_pend", pending, 32'h0000_0088);
    tick();
    chk("waw_draining", {31'd0, draining}, 1);
    chk("waw_p0_blocked2", {31'd0, p0_ready}, 0);
    tick();
    chk("waw_normal", {31'd0, draining}, 0);
    chk("waw_p0_ready", {31'd0, p0_ready}, 1);
    expect_wr(5'd7, 32'h7777_0002);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Full FIFO: p0 writes every cycle while four LSU results fill the FIFO;
    // the fifth is held until a slot frees, then lands in wrapped slot 0.
    j = 0;
    for (int c = 0; c <= 10; c++) begin
      er = (c <= 3) || (c >= 7);
      drive(c <= 5, 5'(c + 1), 32'hA100_0000 + c,
            j < 5, 5'(10 + j), 32'hB100_0000 + j);
      if (c <= 5) begin
        chk("full_p0_ready", {31'd0, p0_ready}, 1);
        expect_wr(5'(c + 1), 32'hA100_0000 + c);
      end
      if (c == 6)
        for (int m = 0; m < 5; m++) expect_wr(5'(10 + m), 32'hB100_0000 + m);
      if (j < 5) chk($sformatf("full_p1_ready_c%0d", c), {31'd0, p1_ready}, {31'd0, er});
      if (c == 4) chk("full_pending", pending, 32'h0000_3C10);
      tick();
      if (er && (j < 5)) j++;
    end
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("full_idle_pending", pending, 0);

    // Starvation: one buffered entry under continuous p0 traffic.
    k = 0;
    for (int c = 0; c <= 11; c++) begin
      drive(1, 5'(1 + (k % 8)), 32'hC000_0000 + k,
            c == 0, 5'd20, 32'h2020_0020);
      chk($sformatf("starve_p0_ready_c%0d", c), {31'd0, p0_ready}, {31'd0, c != 10});
      chk($sformatf("starve_draining_c%0d", c), {31'd0, draining}, {31'd0, c == 10});
      if (c == 10) expect_wr(5'd20, 32'h2020_0020);
      else begin
        expect_wr(5'(1 + (k % 8)), 32'hC000_0000 + k);
        k++;
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // x0: both ports accept rd=0 and nothing is written or buffered.
    drive(1, 5'd0, 32'hDEAD_0000, 1, 5'd0, 32'hDEAD_0001);
    chk("x0_p0_ready", {31'd0, p0_ready}, 1);
    chk("x0_p1_ready", {31'd0, p1_ready}, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk("x0_we", {31'd0, we}, 0);
      chk("x0_pending", pending, 0);
      tick();
    end

    // Reset mid-operation with two entries buffered.
    drive(1, 5'd1, 32'h1111_0001, 1, 5'd8, 32'h8888_0001);
    expect_wr(5'd1, 32'h1111_0001);
    tick();
    drive(1, 5'd2, 32'h1111_0002, 1, 5'd9, 32'h8888_0002);
    expect_wr(5'd2, 32'h1111_0002);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("mid_pend_before", pending, 32'h0000_0304);
    rst = 1'b1;
    tick();
    chk("mid_rst_we", {31'd0, we}, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_p1_ready", {31'd0, p1_ready}, 1);
    chk("mid_rst_draining", {31'd0, draining}, 0);
    rst = 1'b0;
    repeat (4) tick();

    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
